// File: rtl/team_wb_pkg.sv
// team_wb_pkg: shared types and constants for the team Wishbone initiator.
package team_wb_pkg;
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    // Wishbone word addresses clear the low byte-offset bits.
    localparam logic [1:0] WORD_ALIGN = 2'b00;
endpackage

// File: rtl/team_wb_manager.sv
// team_wb_manager: single-transfer Wishbone classic initiator for a CPU-style strobe port.
// Optional bus timeout enabled by defining WB_MANAGER_TIMEOUT_EN.
module team_wb_manager
    import team_wb_pkg::*;
#(
    parameter int ADDR_W         = WB_ADDR_W,
    parameter int DATA_W         = WB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                cpu_read_i,
    input  logic                cpu_write_i,
    input  logic [ADDR_W-1:0]   cpu_adr_i,
    input  logic [DATA_W-1:0]   cpu_dat_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    output logic [DATA_W-1:0]   cpu_dat_o,
    output logic                cpu_busy_o,
    output logic                cpu_done_o,
    output logic                cpu_err_o,
    output logic [ADDR_W-1:0]   adr_o,
    output logic [DATA_W-1:0]   dat_o,
    output logic [DATA_W/8-1:0] sel_o,
    output logic                we_o,
    output logic                cyc_o,
    output logic                stb_o,
    input  logic [DATA_W-1:0]   dat_i,
    input  logic                ack_i
);
    state_t state, state_nxt;
    logic [DATA_W-1:0]   dat_r;
    logic [DATA_W/8-1:0] sel_r;
    logic                we_r;
    logic                err_r;
    logic                req;
    logic                timeout;

    assign req = cpu_read_i | cpu_write_i;

`ifdef WB_MANAGER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            cnt <= '0;
        else if (state != BUS)
            cnt <= '0;
        else if (!ack_i)
            cnt <= cnt + 1'b1;
    end
    // The edge that would bring the count to the limit abandons the transfer; an ack wins.
    assign timeout = (state == BUS) && !ack_i && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE)
            state_nxt = req ? BUS : IDLE;
        else if (state == BUS)
            state_nxt = (ack_i || timeout) ? DONE : BUS;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            adr_o     <= '0;
            dat_r     <= '0;
            sel_r     <= '0;
            we_r      <= 1'b0;
            cpu_dat_o <= '0;
            err_r     <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                adr_o <= {cpu_adr_i[ADDR_W-1:2], WORD_ALIGN};
                dat_r <= cpu_dat_i;
                sel_r <= cpu_sel_i;
                we_r  <= cpu_write_i;
            end
            if (state == BUS && ack_i && !we_r)
                cpu_dat_o <= dat_i;
            err_r <= timeout;
        end
    end

    assign cyc_o      = (state == BUS);
    assign stb_o      = cyc_o;
    assign we_o       = cyc_o & we_r;
    assign sel_o      = cyc_o ? sel_r : '0;
    assign dat_o      = cyc_o ? dat_r : '0;
    assign cpu_busy_o = (state != IDLE);
    assign cpu_done_o = (state == DONE);
    assign cpu_err_o  = err_r & cpu_done_o;
endmodule

// File: tb/tb_team_wb_manager.sv
// tb_team_wb_manager: directed and randomized checks of team_wb_manager against a transaction-level model.
module tb_team_wb_manager;
    localparam int TO = 4;
    logic        clk = 1'b0, nrst = 1'b0;
    logic        cpu_read_i = 1'b0, cpu_write_i = 1'b0;
    logic [31:0] cpu_adr_i = '0, cpu_dat_i = '0, dat_i = '0;
    logic [3:0]  cpu_sel_i = '0;
    logic        ack_i = 1'b0;
    logic [31:0] cpu_dat_o, adr_o, dat_o;
    logic [3:0]  sel_o;
    logic        cpu_busy_o, cpu_done_o, cpu_err_o, we_o, cyc_o, stb_o;
    int          n_cmp = 0, n_err = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    team_wb_manager #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i), .cpu_adr_i(cpu_adr_i),
        .cpu_dat_i(cpu_dat_i), .cpu_sel_i(cpu_sel_i), .cpu_dat_o(cpu_dat_o),
        .cpu_busy_o(cpu_busy_o), .cpu_done_o(cpu_done_o), .cpu_err_o(cpu_err_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request; the responder acks after w wait states. Extra issues a stray read strobe mid-transfer.
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int w, input logic [31:0] rdat, input bit extra);
        int cyc_cnt = 0, busy_cnt = 0, done_cnt = 0, err_cnt = 0, done_at = -1;
        @(negedge clk);
        cpu_read_i = rd; cpu_write_i = wr; cpu_adr_i = a; cpu_dat_i = d; cpu_sel_i = s;
        @(negedge clk);
        cpu_read_i = 1'b0; cpu_write_i = 1'b0;
        cpu_adr_i = $urandom; cpu_dat_i = $urandom; cpu_sel_i = 4'($urandom);
        if (!wr) exp_rdata = rdat;
        for (int c = 0; c < w + 6; c++) begin
            check("stb_eq_cyc", 32'(stb_o), 32'(cyc_o));
            if (cyc_o) begin
                cyc_cnt++;
                check("adr", adr_o, {a[31:2], 2'b00});
                check("we", 32'(we_o), 32'(wr));
                check("sel", 32'(sel_o), 32'(s));
                if (wr) check("dat_o", dat_o, d);
            end else begin
                check("idle_bus_zero", {dat_o[27:0], sel_o}, 32'h0);
                check("idle_we_zero", 32'(we_o), 32'h0);
            end
            busy_cnt += int'(cpu_busy_o);
            err_cnt  += int'(cpu_err_o);
            if (cpu_done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            ack_i = (c == w);
            dat_i = ack_i ? rdat : $urandom;
            cpu_read_i = extra && (c == 0);
            @(negedge clk);
        end
        ack_i = 1'b0; cpu_read_i = 1'b0;
        check("cyc_cycles", 32'(cyc_cnt), 32'(w + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(w + 2));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_at), 32'(w + 1));
        check("no_err", 32'(err_cnt), 32'd0);
        check("cpu_dat", cpu_dat_o, exp_rdata);
    endtask

    initial begin
        int cyc_cnt, done_at, err_cnt;
        #1;
        check("rst_cpu_dat", cpu_dat_o, 32'h0);
        check("rst_adr", adr_o, 32'h0);
        check("rst_flags", {25'h0, cpu_busy_o, cpu_done_o, cpu_err_o, we_o, cyc_o, stb_o, 1'b0}, 32'h0);
        check("rst_bus", {dat_o[27:0], sel_o}, 32'h0);
        @(negedge clk); nrst = 1'b1;

        xfer(1'b0, 1'b1, 32'h3000_0006, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
        xfer(1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'h0000_0007, 1'b0);
        xfer(1'b1, 1'b0, 32'h3000_0020, 32'h0, 4'h3, 2, 32'h1234_5678, 1'b1);
        xfer(1'b1, 1'b1, 32'h3000_0033, 32'hCAFE_F00D, 4'h5, 1, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 25; i++) begin
            bit rd = 1'($urandom), wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            xfer(rd, wr, $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 4)),
                 $urandom, 1'($urandom));
        end

        // Asynchronous reset during wait states.
        @(negedge clk);
        cpu_read_i = 1'b1; cpu_adr_i = 32'h3000_0040;
        @(negedge clk); cpu_read_i = 1'b0;
        @(negedge clk);
        check("pre_rst_cyc", 32'(cyc_o), 32'h1);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_cyc", {30'h0, cyc_o, stb_o}, 32'h0);
        check("async_rst_busy", 32'(cpu_busy_o), 32'h0);
        check("async_rst_dat", cpu_dat_o, 32'h0);
        exp_rdata = '0;
        @(negedge clk); nrst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            ack_i = 1'b1;
            check("post_rst_quiet", {29'h0, cpu_done_o, cpu_err_o, cyc_o}, 32'h0);
            @(negedge clk);
        end
        ack_i = 1'b0;
        xfer(1'b1, 1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'hA5A5_5A5A, 1'b0);

        // Responder never acks.
        @(negedge clk);
        cpu_read_i = 1'b1; cpu_adr_i = 32'h3000_0048;
        @(negedge clk); cpu_read_i = 1'b0;
        cyc_cnt = 0; done_at = -1; err_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            dat_i = $urandom;
            cyc_cnt += int'(cyc_o);
            err_cnt += int'(cpu_err_o);
            if (cpu_done_o && done_at < 0) begin
                done_at = c;
                check("to_err_with_done", 32'(cpu_err_o), 32'h1);
            end
            @(negedge clk);
        end
`ifdef WB_MANAGER_TIMEOUT_EN
        check("to_cyc_cycles", 32'(cyc_cnt), 32'(TO));
        check("to_done_at", 32'(done_at), 32'(TO));
        check("to_err_pulses", 32'(err_cnt), 32'h1);
        check("to_cpu_dat", cpu_dat_o, exp_rdata);
`else
        check("noto_cyc_cycles", 32'(cyc_cnt), 32'd20);
        check("noto_no_done", 32'(done_at), 32'hFFFF_FFFF);
        check("noto_no_err", 32'(err_cnt), 32'h0);
        nrst = 1'b0;
        @(negedge clk); nrst = 1'b1;
        exp_rdata = '0;
`endif
        xfer(1'b0, 1'b1, 32'h3000_004C, 32'h0BAD_F00D, 4'h8, 2, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
